// File: rtl/dw8051_rom_pkg.sv
// Shared types and widths for the program-ROM access arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dw8051_rom_pkg;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 8;
    // Wide enough for the largest allowed starvation limit (15).
    localparam int STARVE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_LAST  = 2'd2
    } dbg_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } gnt_owner_t;

endpackage

// File: rtl/rom_access_arb_if.sv
// Bundles the CPU fetch port, the debug burst port and the ROM pins.
// Latency: n/a (wiring only).
// Backpressure: CPU holds cpu_req/cpu_addr until cpu_gnt; debug start is ignored while busy.
interface rom_access_arb_if #(
    parameter int LEN_W = 8
);
    import dw8051_rom_pkg::*;

    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_start;
    logic [ADDR_W-1:0] dbg_addr;
    logic [LEN_W-1:0]  dbg_len;
    logic              dbg_busy;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_done;

    logic [ADDR_W-1:0] rom_addr;
    logic              rom_cs_n;
    logic              rom_rd_n;
    logic [DATA_W-1:0] rom_data;

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_addr, dbg_start, dbg_addr, dbg_len, rom_data,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_busy, dbg_rvalid, dbg_rdata, dbg_done,
        output rom_addr, rom_cs_n, rom_rd_n
    );

    // Requester / ROM side.
    modport master (
        output cpu_req, cpu_addr, dbg_start, dbg_addr, dbg_len, rom_data,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_busy, dbg_rvalid, dbg_rdata, dbg_done,
        input  rom_addr, rom_cs_n, rom_rd_n
    );

endinterface

// File: rtl/rom_starve_ctr.sv
// Counts consecutive denied debug cycles, saturating at LIMIT, and flags the limit.
// Latency: o_at_limit is a decode of the registered count (visible the cycle after the increment).
// Backpressure: none; clear has priority over increment.
module rom_starve_ctr #(
    parameter int W     = 4,
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit
);

    logic [W-1:0] r_cnt;

    // Saturating up-counter with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != W'(LIMIT))) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_at_limit = (r_cnt == W'(LIMIT));

endmodule

// File: rtl/rom_access_arb.sv
// Shares the single-port program ROM between CPU fetches and debug bursts, CPU first with a starvation escape.
// Latency: grant is combinational; read data and rvalid appear exactly one cycle after the grant.
// Backpressure: a denied CPU keeps requesting; a denied burst stalls its address until granted.
module rom_access_arb
    import dw8051_rom_pkg::*;
#(
    parameter int LEN_W      = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    rom_access_arb_if.slave bus
);

    dbg_state_t        r_state;
    logic [ADDR_W-1:0] r_bst_addr;
    logic [LEN_W-1:0]  r_bst_cnt;
    logic              r_dbg_busy;
    logic              r_dbg_done;
    logic              r_cpu_rvalid;
    logic              r_dbg_rvalid;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dbg_rdata;

    gnt_owner_t        w_owner;
    logic              w_dbg_want;
    logic              w_starved;
    logic              w_cpu_gnt;
    logic              w_dbg_gnt;
    logic [ADDR_W-1:0] w_rom_addr;

    assign w_dbg_want = (r_state == ST_BURST);

    // Pick this cycle's ROM owner: CPU wins contention unless the burst has waited too long.
    always_comb begin
        w_owner = OWN_NONE;
        if (w_dbg_want && (!bus.cpu_req || w_starved)) begin
            w_owner = OWN_DBG;
        end else if (bus.cpu_req) begin
            w_owner = OWN_CPU;
        end
    end

    assign w_cpu_gnt = (w_owner == OWN_CPU);
    assign w_dbg_gnt = (w_owner == OWN_DBG);

    // Steer the ROM address from the owner; park at zero when nobody owns the ROM.
    always_comb begin
        w_rom_addr = '0;
        case (w_owner)
            OWN_CPU: w_rom_addr = bus.cpu_addr;
            OWN_DBG: w_rom_addr = r_bst_addr;
            default: w_rom_addr = '0;
        endcase
    end

    // Leaving BURST always coincides with a debug grant, so clearing on grant or when not wanting covers it.
    rom_starve_ctr #(
        .W     (STARVE_W),
        .LIMIT (STARVE_MAX)
    ) u_starve (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_inc      (w_dbg_want && !w_dbg_gnt),
        .i_clr      (w_dbg_gnt || !w_dbg_want),
        .o_at_limit (w_starved)
    );

    // Debug burst sequencer; LAST is the cycle the final beat's data and done are presented.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_bst_addr <= '0;
            r_bst_cnt  <= '0;
            r_dbg_busy <= 1'b0;
            r_dbg_done <= 1'b0;
        end else begin
            r_dbg_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.dbg_start) begin
                        r_bst_addr <= bus.dbg_addr;
                        r_bst_cnt  <= bus.dbg_len;
                        r_state    <= ST_BURST;
                        r_dbg_busy <= 1'b1;
                    end
                end
                ST_BURST: begin
                    if (w_dbg_gnt) begin
                        r_bst_addr <= r_bst_addr + ADDR_W'(1);
                        if (r_bst_cnt == '0) begin
                            r_state    <= ST_LAST;
                            r_dbg_done <= 1'b1;
                        end else begin
                            r_bst_cnt <= r_bst_cnt - LEN_W'(1);
                        end
                    end
                end
                ST_LAST: begin
                    r_state    <= ST_IDLE;
                    r_dbg_busy <= 1'b0;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_dbg_busy <= 1'b0;
                end
            endcase
        end
    end

    // Capture the ROM byte for whichever port owned the cycle; data holds when not refreshed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
            r_dbg_rdata  <= '0;
        end else begin
            r_cpu_rvalid <= w_cpu_gnt;
            r_dbg_rvalid <= w_dbg_gnt;
            if (w_cpu_gnt) begin
                r_cpu_rdata <= bus.rom_data;
            end
            if (w_dbg_gnt) begin
                r_dbg_rdata <= bus.rom_data;
            end
        end
    end

    assign bus.cpu_gnt    = w_cpu_gnt;
    assign bus.cpu_rvalid = r_cpu_rvalid;
    assign bus.cpu_rdata  = r_cpu_rdata;
    assign bus.dbg_busy   = r_dbg_busy;
    assign bus.dbg_rvalid = r_dbg_rvalid;
    assign bus.dbg_rdata  = r_dbg_rdata;
    assign bus.dbg_done   = r_dbg_done;
    assign bus.rom_addr   = w_rom_addr;
    assign bus.rom_cs_n   = (w_owner == OWN_NONE);
    assign bus.rom_rd_n   = (w_owner == OWN_NONE);

endmodule

// File: tb/tb_rom_access_arb.sv
// Directed bench for the ROM access arbiter: CPU reads, debug bursts, starvation, wrap, reset.
// Latency: checks sample 1 time unit after the falling edge.
// Backpressure: CPU requester holds its address until granted.
module tb_rom_access_arb;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    rom_access_arb_if #(.LEN_W(8)) bus ();

    rom_access_arb #(
        .LEN_W      (8),
        .STARVE_MAX (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // ROM contents: address-derived pattern with one planted byte.
    function automatic logic [7:0] rom_fn(input logic [15:0] a);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = a[7:0];
        hi = a[15:8];
        if (a == 16'h0010) return 8'hA5;
        return 8'(lo * 8'd7) ^ 8'(hi * 8'd13) ^ 8'h3C;
    endfunction

    assign bus.rom_data = rom_fn(bus.rom_addr);

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts a burst and checks every cycle: grants, addresses, data, done, CPU traffic.
    // With hammer=1 the CPU requests every cycle, so the burst wins only every 5th contended cycle.
    task automatic run_burst(input logic [15:0] a0, input logic [7:0] len,
                             input bit hammer, input bit poke);
        int          n;
        int          ng;
        int          nrv;
        bit          p_dg;
        bit          p_cg;
        bit          p_last;
        bit          exp_g;
        bit          obs_g;
        bit          fin;
        logic [15:0] p_da;
        logic [15:0] p_ca;
        logic [15:0] c_addr;
        n = int'(len) + 1;
        ng = 0; nrv = 0; p_dg = 0; p_cg = 0; p_last = 0; fin = 0;
        p_da = '0; p_ca = '0; c_addr = 16'h2000 ^ a0;

        @(negedge clk);
        bus.cpu_req   = 1'b0;
        bus.dbg_start = 1'b1;
        bus.dbg_addr  = a0;
        bus.dbg_len   = len;
        #1 chk("start_busy", 16'(bus.dbg_busy), 16'd0);
        @(negedge clk);
        bus.dbg_addr = '0;
        bus.dbg_len  = '0;
        for (int k = 0; k < 2000; k++) begin
            bus.cpu_req  = hammer;
            bus.cpu_addr = c_addr;
            if (poke && k == 1) begin
                bus.dbg_start = 1'b1;
                bus.dbg_addr  = 16'h5555;
                bus.dbg_len   = 8'h10;
            end else begin
                bus.dbg_start = 1'b0;
            end
            exp_g = (ng < n) && (!hammer || (k % 5 == 4));
            #1;
            obs_g = !bus.rom_cs_n && !bus.cpu_gnt;
            chk("bst_busy", 16'(bus.dbg_busy), 16'd1);
            chk("bst_dbg_gnt", 16'(obs_g), 16'(exp_g));
            chk("bst_cpu_gnt", 16'(bus.cpu_gnt), 16'(hammer && !exp_g));
            if (exp_g) chk("bst_rom_addr", bus.rom_addr, a0 + 16'(ng));
            else if (hammer) chk("cpu_rom_addr", bus.rom_addr, c_addr);
            chk("bst_dbg_rv", 16'(bus.dbg_rvalid), 16'(p_dg));
            if (p_dg) begin
                chk("bst_dbg_rdata", 16'(bus.dbg_rdata), 16'(rom_fn(p_da)));
                nrv++;
            end
            chk("bst_dbg_done", 16'(bus.dbg_done), 16'(p_last));
            chk("bst_cpu_rv", 16'(bus.cpu_rvalid), 16'(p_cg));
            if (p_cg) chk("bst_cpu_rdata", 16'(bus.cpu_rdata), 16'(rom_fn(p_ca)));
            fin    = p_last;
            p_last = exp_g && (ng == n - 1);
            p_dg   = exp_g;
            p_da   = a0 + 16'(ng);
            p_cg   = hammer && !exp_g;
            p_ca   = c_addr;
            if (exp_g) ng++;
            if (p_cg) c_addr = c_addr + 16'd3;
            if (fin) break;
            @(negedge clk);
        end
        chk("bst_fin", 16'(fin), 16'd1);
        chk("bst_beats", 16'(nrv), 16'(n));
        @(negedge clk);
        bus.cpu_req   = 1'b0;
        bus.dbg_start = 1'b0;
        #1;
        chk("bst_idle_busy", 16'(bus.dbg_busy), 16'd0);
        chk("bst_idle_rv", 16'(bus.dbg_rvalid), 16'd0);
        chk("bst_tail_cpu_rv", 16'(bus.cpu_rvalid), 16'(p_cg));
        if (p_cg) chk("bst_tail_cpu_rdata", 16'(bus.cpu_rdata), 16'(rom_fn(p_ca)));
    endtask

    initial begin
        bus.cpu_req   = 1'b0;
        bus.cpu_addr  = '0;
        bus.dbg_start = 1'b0;
        bus.dbg_addr  = '0;
        bus.dbg_len   = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cpu_rv", 16'(bus.cpu_rvalid), 16'd0);
        chk("rst_dbg_rv", 16'(bus.dbg_rvalid), 16'd0);
        chk("rst_busy", 16'(bus.dbg_busy), 16'd0);
        chk("rst_done", 16'(bus.dbg_done), 16'd0);
        chk("rst_cpu_rdata", 16'(bus.cpu_rdata), 16'd0);
        chk("rst_dbg_rdata", 16'(bus.dbg_rdata), 16'd0);
        chk("rst_cs_n", 16'(bus.rom_cs_n), 16'd1);
        chk("rst_rd_n", 16'(bus.rom_rd_n), 16'd1);
        chk("rst_rom_addr", bus.rom_addr, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Single CPU read of the planted byte.
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 16'h0010;
        #1;
        chk("cpu_gnt", 16'(bus.cpu_gnt), 16'd1);
        chk("cpu_cs_n", 16'(bus.rom_cs_n), 16'd0);
        chk("cpu_rd_n", 16'(bus.rom_rd_n), 16'd0);
        chk("cpu_rom_addr0", bus.rom_addr, 16'h0010);
        chk("cpu_rv_early", 16'(bus.cpu_rvalid), 16'd0);
        @(negedge clk);
        bus.cpu_req = 1'b0;
        #1;
        chk("cpu_rv", 16'(bus.cpu_rvalid), 16'd1);
        chk("cpu_rdata", 16'(bus.cpu_rdata), 16'h00A5);
        chk("cpu_cs_idle", 16'(bus.rom_cs_n), 16'd1);
        chk("cpu_dbg_rv", 16'(bus.dbg_rvalid), 16'd0);
        @(negedge clk);
        #1;
        chk("cpu_rv_drop", 16'(bus.cpu_rvalid), 16'd0);
        chk("cpu_rdata_hold", 16'(bus.cpu_rdata), 16'h00A5);

        // Back-to-back CPU reads: one byte per cycle.
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 16'h0020;
        #1 chk("b2b_gnt0", 16'(bus.cpu_gnt), 16'd1);
        @(negedge clk);
        bus.cpu_addr = 16'h0021;
        #1;
        chk("b2b_gnt1", 16'(bus.cpu_gnt), 16'd1);
        chk("b2b_rv0", 16'(bus.cpu_rvalid), 16'd1);
        chk("b2b_rdata0", 16'(bus.cpu_rdata), 16'(rom_fn(16'h0020)));
        @(negedge clk);
        bus.cpu_req = 1'b0;
        #1;
        chk("b2b_rv1", 16'(bus.cpu_rvalid), 16'd1);
        chk("b2b_rdata1", 16'(bus.cpu_rdata), 16'(rom_fn(16'h0021)));

        run_burst(16'h0100, 8'd3, 1'b0, 1'b0);   // plain 4-beat burst
        run_burst(16'h3000, 8'd1, 1'b1, 1'b0);   // starvation escape under CPU load
        run_burst(16'hFFFE, 8'd3, 1'b0, 1'b0);   // address wrap
        run_burst(16'h0040, 8'd2, 1'b0, 1'b1);   // start pulse while busy is ignored
        run_burst(16'h0080, 8'd0, 1'b0, 1'b0);   // single-beat burst

        // One-cycle reset in the middle of a burst.
        @(negedge clk);
        bus.dbg_start = 1'b1;
        bus.dbg_addr  = 16'h0200;
        bus.dbg_len   = 8'd7;
        @(negedge clk);
        bus.dbg_start = 1'b0;
        @(negedge clk);
        #1 chk("mid_pre_rv", 16'(bus.dbg_rvalid), 16'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_busy", 16'(bus.dbg_busy), 16'd0);
        chk("mid_rv", 16'(bus.dbg_rvalid), 16'd0);
        chk("mid_done", 16'(bus.dbg_done), 16'd0);
        chk("mid_cs_n", 16'(bus.rom_cs_n), 16'd1);
        chk("mid_rdata", 16'(bus.dbg_rdata), 16'd0);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("mid_quiet_rv", 16'(bus.dbg_rvalid), 16'd0);
            chk("mid_quiet_cs", 16'(bus.rom_cs_n), 16'd1);
        end
        run_burst(16'h0300, 8'd2, 1'b0, 1'b0);   // normal burst after reset

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_access_arb.md
Name: rom_access_arb

Overview:
- Arbitrates the single-port program ROM between two requesters:
  - the DW8051 core's code-fetch/MOVC port (CPU);
  - a debug/loader burst reader (DBG) used for ROM dump and checksum.
- Generates the ROM chip-select, read strobe and address.
- Registers the returned byte, so each requester sees a fixed one-cycle read latency.
- Sits between the core and the ROM model in the DW8051 top level.

Parameters:
- ADDR_W, 16, ROM address width.
- DATA_W, 8, ROM data width.
- LEN_W, 8, burst length field width; a burst is dbg_len+1 bytes.
- STARVE_MAX, 4, consecutive DBG-denied cycles before DBG is forced a slot; legal range 1..15.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- cpu_req  input  1  CPU read request; held with cpu_addr stable until cpu_gnt.
- cpu_addr  input  ADDR_W  CPU read address.
- cpu_gnt  output  1  CPU request accepted this cycle (combinational).
- cpu_rvalid  output  1  cpu_rdata valid; registered, one cycle after cpu_gnt.
- cpu_rdata  output  DATA_W  CPU read data, registered.
- dbg_start  input  1  single-cycle pulse; starts a burst when dbg_busy=0.
- dbg_addr  input  ADDR_W  burst start address, sampled on accepted dbg_start.
- dbg_len  input  LEN_W  beats minus one, sampled on accepted dbg_start.
- dbg_busy  output  1  burst in progress (registered).
- dbg_rvalid  output  1  dbg_rdata valid, one per beat.
- dbg_rdata  output  DATA_W  burst data, in address order.
- dbg_done  output  1  one-cycle pulse, same cycle as the final dbg_rvalid.
- rom_addr  output  ADDR_W  ROM address (combinational mux).
- rom_cs_n  output  1  ROM chip select, low on any granted cycle.
- rom_rd_n  output  1  ROM read strobe, low on any granted cycle.
- rom_data  input  DATA_W  ROM read data, combinational from rom_addr.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - FSM goes to IDLE; starve counter and beat counter clear.
  - cpu_rvalid, dbg_rvalid, dbg_done and dbg_busy are 0.
  - cpu_rdata and dbg_rdata are 0.
  - Reset mid-burst drops any in-flight beat; no rvalid or done follows.
- Reset outputs while idle: rom_cs_n=1, rom_rd_n=1, rom_addr=0.
- DBG FSM states: IDLE, BURST, LAST.
  - IDLE: dbg_start=1 latches bst_addr<=dbg_addr and bst_cnt<=dbg_len, then moves to BURST.
  - IDLE: dbg_busy=0.
  - dbg_busy=1 in BURST and LAST.
  - BURST: dbg_want=1.
  - BURST, on a DBG-granted cycle: bst_addr<=bst_addr+1, wrapping FFFF->0000.
  - BURST, DBG-granted with bst_cnt==0: go to LAST.
  - BURST, DBG-granted with bst_cnt!=0: bst_cnt decrements.
  - LAST: no request; the final beat's rvalid and dbg_done assert; return to IDLE next cycle.
  - dbg_start while dbg_busy=1 is ignored.
- Arbitration, evaluated each cycle:
  - Only CPU wants: CPU granted.
  - Only DBG wants: DBG granted.
  - Both want: CPU wins unless starve_cnt==STARVE_MAX, in which case DBG wins and cpu_gnt=0.
  - starve_cnt increments on each cycle DBG wants but is denied.
  - starve_cnt clears on a DBG grant and on leaving BURST.
- Granted cycle N:
  - rom_addr = winner's address; rom_cs_n=0, rom_rd_n=0.
  - rom_data is captured at the edge ending N.
  - The winner's rvalid is 1 during N+1 with the captured byte.
- Back-to-back grants give one byte per cycle with no bubble.
- rvalid for each port is strictly one cycle after that port's grant; the two rvalids are never both 1.
- The rdata registers hold their last value when rvalid=0.
- Burst of dbg_len=0 is one beat; dbg_len=FF is 256 beats.

Decomposition:
- Shared package dw8051_rom_pkg holds:
  - ADDR_W and DATA_W constants;
  - the DBG FSM state enum (IDLE/BURST/LAST);
  - the grant-owner encoding (NONE/CPU/DBG).
- No sub-module is needed; the arbiter and FSM stay in one module.
- Optional sub-module rom_starve_ctr: saturating counter with clear and a limit compare.

Test Plan:
- CPU only, cpu_req=1, cpu_addr=0x0010, ROM[0x10]=0xA5:
  - cpu_gnt=1 same cycle with rom_cs_n=0;
  - next cycle cpu_rvalid=1 and cpu_rdata=0xA5.
- DBG burst dbg_addr=0x0100, dbg_len=3, CPU idle:
  - 4 consecutive dbg_rvalid beats returning ROM[0x100..0x103];
  - dbg_done pulses with the 4th beat; dbg_busy then drops.
- Starvation, STARVE_MAX=4, CPU requesting every cycle during a burst with dbg_len=1:
  - DBG is granted on every 5th contended cycle, with cpu_gnt=0 in that cycle;
  - CPU data is never corrupted.
- Wrap: dbg_addr=0xFFFE, dbg_len=3 returns ROM[FFFE], ROM[FFFF], ROM[0000], ROM[0001].
- dbg_start pulsed while busy: the burst is unaffected and beat count stays dbg_len+1.
- rst_n=0 for one cycle mid-burst:
  - next cycle dbg_busy=0, no further dbg_rvalid, rom_cs_n=1;
  - a new dbg_start afterwards runs normally.
